jk_reg_counter: RTL and testbench

- Parametrised WIDTH-bit register built from per-bit JK flip-flop cells. It is the multi-bit successor to the single jkff.
- Four modes: per-bit JK, parallel load, up/down count (wrap or saturate), and hold.
- Used as a general-purpose state/count register in sequential-circuit designs.
- Every mode is expressed as J/K drive to the cells, so JK semantics are preserved bit-exact.

---
 rtl/jk_pkg.sv | 11 +
 rtl/jk_bit.sv | 27 ++
 rtl/jk_reg_counter.sv | 99 +++++++++
 tb/tb_jk_reg_counter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK-cell register family.
package jk_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK    = 2'b00;
    localparam mode_t MODE_LOAD  = 2'b01;
    localparam mode_t MODE_COUNT = 2'b10;
    localparam mode_t MODE_HOLD  = 2'b11;

endpackage

// File: rtl/jk_bit.sv
// Single JK flip-flop cell with asynchronous active-low reset to a per-bit value.
module jk_bit (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= rst_val;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/jk_reg_counter.sv
// WIDTH-bit register of JK cells; every mode (JK, load, count, hold) is expressed
// purely as J/K steering so the cell semantics are preserved bit-exact.
module jk_reg_counter
    import jk_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic             up,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap
);

    localparam bit SAT = (SATURATE != 0);

    logic [WIDTH-1:0] jv;
    logic [WIDTH-1:0] kv;
    logic [WIDTH-1:0] tgl;
    logic             wrap_next;

    // Bit i toggles when every lower bit already equals the direction bit
    // (all ones going up, all zeros going down): a ripple-free carry chain.
    always_comb begin : p_tgl
        logic hit;
        hit = 1'b1;
        tgl = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit = 1'b1;
            for (int b = 0; b < WIDTH; b++) begin
                if ((b < i) && (q[b] != up)) hit = 1'b0;
            end
            tgl[i] = hit;
        end
    end

    assign tc = en && (mode == MODE_COUNT) && (up ? (&q) : (~|q));

    always_comb begin
        jv        = '0;
        kv        = '0;
        wrap_next = 1'b0;
        if (en) begin
            case (mode)
                MODE_JK: begin
                    jv = j;
                    kv = k;
                end
                MODE_LOAD: begin
                    jv = d;
                    kv = ~d;
                end
                MODE_COUNT: begin
                    // Saturating instances freeze at the boundary instead of wrapping.
                    if (!(SAT && tc)) begin
                        jv        = tgl;
                        kv        = tgl;
                        wrap_next = tc;
                    end
                end
                default: begin
                    jv = '0;
                    kv = '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_bit u_bit (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_VAL[i]),
            .j       (jv[i]),
            .k       (kv[i]),
            .q       (q[i]),
            .qb      (qb[i])
        );
    end

    // Registered on the same edge as the wrap, so it lines up with the wrapped q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_jk_reg_counter.sv
// Directed bench: wrapping, saturating and RST_VAL=5 instances share one stimulus stream.
module tb_jk_reg_counter;
    import jk_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    mode_t        mode = MODE_HOLD;
    logic         up  = 1'b1;
    logic [W-1:0] j   = '0;
    logic [W-1:0] k   = '0;
    logic [W-1:0] d   = '0;

    logic [W-1:0] q_w, qb_w, q_s, qb_s, q_r, qb_r;
    logic         tc_w, wrap_w, tc_s, wrap_s, tc_r, wrap_r;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    jk_reg_counter #(.WIDTH(W), .RST_VAL(4'h0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .up(up), .j(j), .k(k), .d(d),
        .q(q_w), .qb(qb_w), .tc(tc_w), .wrap(wrap_w)
    );

    jk_reg_counter #(.WIDTH(W), .RST_VAL(4'h0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .up(up), .j(j), .k(k), .d(d),
        .q(q_s), .qb(qb_s), .tc(tc_s), .wrap(wrap_s)
    );

    jk_reg_counter #(.WIDTH(W), .RST_VAL(4'h5), .SATURATE(0)) u_rv (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .up(up), .j(j), .k(k), .d(d),
        .q(q_r), .qb(qb_r), .tc(tc_r), .wrap(wrap_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input mode_t m, input logic u,
                         input logic [W-1:0] jj, input logic [W-1:0] kk,
                         input logic [W-1:0] dd, input logic [W-1:0] expect_q);
        en   = e;
        mode = m;
        up   = u;
        j    = jj;
        k    = kk;
        d    = dd;
        exp_q.push_back(expect_q);
    endtask

    // Advance one edge and score the wrapping instance's q against the queue head.
    task automatic cycle(input string tag);
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_q"}, q_w, e);
        end
    endtask

    initial begin
        // Reset asserted before any edge must act immediately.
        #3 rst = 1'b0;
        #1;
        chk("rst_q",     q_w,    4'h0);
        chk("rst_qb",    qb_w,   4'hF);
        chk("rst_wrap",  wrap_w, 1'b0);
        chk("rst_rv_q",  q_r,    4'h5);
        chk("rst_rv_qb", qb_r,   4'hA);
        #2 rst = 1'b1;

        // en=0 holds even in COUNT mode.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, MODE_COUNT, 1'b1, '0, '0, '0, 4'h0);
            #1;
            chk("en0_tc", tc_w, 1'b0);
            cycle("en0");
            chk("en0_qb", qb_w, 4'hF);
            chk("en0_wrap", wrap_w, 1'b0);
        end

        // JK mode: toggle / set / clear / hold per bit.
        drive(1'b1, MODE_LOAD, 1'b1, '0, '0, 4'hC, 4'hC);
        cycle("load_c");
        drive(1'b1, MODE_JK, 1'b1, 4'b0011, 4'b0101, '0, 4'b1011);
        cycle("jk");
        chk("jk_qb", qb_w, 4'b0100);

        // Count up through the wrap; saturating instance pins at F.
        drive(1'b1, MODE_LOAD, 1'b1, '0, '0, 4'hE, 4'hE);
        cycle("load_e");
        drive(1'b1, MODE_COUNT, 1'b1, '0, '0, '0, 4'hF);
        #1;
        chk("up_tc_at_e", tc_w, 1'b0);
        cycle("up1");
        chk("up1_tc", tc_w, 1'b1);
        chk("up1_wrap", wrap_w, 1'b0);
        chk("sat_up1_q", q_s, 4'hF);
        chk("sat_up1_tc", tc_s, 1'b1);
        exp_q.push_back(4'h0);
        cycle("up2");
        chk("up2_wrap", wrap_w, 1'b1);
        chk("up2_tc", tc_w, 1'b0);
        chk("sat_up2_q", q_s, 4'hF);
        chk("sat_up2_wrap", wrap_s, 1'b0);
        exp_q.push_back(4'h1);
        cycle("up3");
        chk("up3_wrap", wrap_w, 1'b0);
        chk("sat_up3_q", q_s, 4'hF);
        chk("sat_up3_tc", tc_s, 1'b1);
        exp_q.push_back(4'h2);
        cycle("up4");
        chk("sat_up4_q", q_s, 4'hF);
        chk("sat_up4_wrap", wrap_s, 1'b0);
        // Direction flips take effect on the very next edge.
        drive(1'b1, MODE_COUNT, 1'b0, '0, '0, '0, 4'h1);
        cycle("dir_flip");
        chk("sat_dir_q", q_s, 4'hE);

        // Count down through the wrap; saturating instance pins at 0.
        drive(1'b1, MODE_LOAD, 1'b0, '0, '0, 4'h1, 4'h1);
        cycle("load_1");
        drive(1'b1, MODE_COUNT, 1'b0, '0, '0, '0, 4'h0);
        cycle("dn1");
        chk("dn1_tc", tc_w, 1'b1);
        chk("dn1_wrap", wrap_w, 1'b0);
        exp_q.push_back(4'hF);
        cycle("dn2");
        chk("dn2_wrap", wrap_w, 1'b1);
        chk("dn2_tc", tc_w, 1'b0);
        chk("sat_dn2_q", q_s, 4'h0);
        chk("sat_dn2_tc", tc_s, 1'b1);
        drive(1'b1, MODE_HOLD, 1'b0, '0, '0, '0, 4'hF);
        cycle("hold");
        chk("hold_wrap", wrap_w, 1'b0);

        // Asynchronous reset in the middle of a count.
        drive(1'b1, MODE_LOAD, 1'b1, '0, '0, 4'h9, 4'h9);
        cycle("load_9");
        chk("rv_load_q", q_r, 4'h9);
        mode = MODE_COUNT;
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_rv_q",  q_r,    4'h5);
        chk("mid_rst_rv_qb", qb_r,   4'hA);
        chk("mid_rst_rv_wrap", wrap_r, 1'b0);
        chk("mid_rst_q",     q_w,    4'h0);
        #1 rst = 1'b1;
        exp_q.push_back(4'h1);
        cycle("resume1");
        chk("resume1_rv_q", q_r, 4'h6);
        exp_q.push_back(4'h2);
        cycle("resume2");
        chk("resume2_rv_q", q_r, 4'h7);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
